// File: rtl/wb_swap_sequencer_pkg.sv
// rtl/wb_swap_sequencer_pkg.sv - shared constants and state encoding for the EX->WB swap sequencer
// Contents: ALU control codes, sequencer state type, default widths.
package wb_swap_sequencer_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int ADDR_W_DEF = 4;
   localparam int CNT_W_DEF  = 16;

   localparam logic [2:0] ALU_ADD  = 3'b000;
   localparam logic [2:0] ALU_SUB  = 3'b001;
   localparam logic [2:0] ALU_MOV  = 3'b010;
   localparam logic [2:0] ALU_SWAP = 3'b011;
   localparam logic [2:0] ALU_AND  = 3'b100;
   localparam logic [2:0] ALU_OR   = 3'b101;

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_WR1   = 2'd1,
      S_WR2   = 2'd2
   } state_t;

   function automatic logic is_swap(input logic [2:0] ctrl);
      return ctrl == ALU_SWAP;
   endfunction

endpackage

// File: rtl/wb_swap_sequencer_sat_counter.sv
// rtl/wb_swap_sequencer_sat_counter.sv - saturating up-counter with synchronous active-low clear
// Ports: clk, clr_n (sync clear, active-low), inc (count enable), count (current value).
module wb_swap_sequencer_sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         clr_n,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk) begin
      if (!clr_n) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/wb_swap_sequencer.sv
// rtl/wb_swap_sequencer.sv - EX->WB write sequencer that splits SWAP into two register-file writes
// Ports: clk, rst_n (sync, active-low), flush (kill pending entry);
//        ex_valid/ex_ready handshake with ex_reg_write, ex_alu_ctrl, ex_result, ex_rd1, ex_rd2;
//        rf_we/rf_waddr/rf_wdata register-file write port;
//        pend_valid/pend_addr outstanding SWAP second write for the hazard unit;
//        wr_count saturating count of committed writes.
module wb_swap_sequencer
   import wb_swap_sequencer_pkg::*;
#(
   parameter int DATA_W      = DATA_W_DEF,
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int ZERO_REG_RO = 1,
   parameter int CNT_W       = CNT_W_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                flush,
   input  logic                ex_valid,
   output logic                ex_ready,
   input  logic                ex_reg_write,
   input  logic [2:0]          ex_alu_ctrl,
   input  logic [2*DATA_W-1:0] ex_result,
   input  logic [ADDR_W-1:0]   ex_rd1,
   input  logic [ADDR_W-1:0]   ex_rd2,
   output logic                rf_we,
   output logic [ADDR_W-1:0]   rf_waddr,
   output logic [DATA_W-1:0]   rf_wdata,
   output logic                pend_valid,
   output logic [ADDR_W-1:0]   pend_addr,
   output logic [CNT_W-1:0]    wr_count
);

   state_t              state;
   logic [2*DATA_W-1:0] res_q;
   logic [ADDR_W-1:0]   rd1_q;
   logic [ADDR_W-1:0]   rd2_q;
   logic                swap_q;

   logic                ready_int;
   logic                wr_act;
   logic                pv_int;
   logic                kill;
   logic                zero_blk;
   logic                take;
   logic [ADDR_W-1:0]   wa;
   logic [DATA_W-1:0]   wd;

   // Outputs decode from the held entry; reset and flush override them
   // combinationally so the write port is quiet in the very cycle they assert.
   always_comb begin
      ready_int = 1'b1;
      wr_act    = 1'b0;
      pv_int    = 1'b0;
      wa        = rd1_q;
      wd        = res_q[DATA_W-1:0];
      case (state)
         S_WR1: begin
            wr_act = 1'b1;
            if (swap_q) begin
               ready_int = 1'b0;
               pv_int    = 1'b1;
            end
         end
         S_WR2: begin
            wr_act = 1'b1;
            wa     = rd2_q;
            wd     = res_q[2*DATA_W-1:DATA_W];
         end
         default: begin
         end
      endcase

      kill       = !rst_n || flush;
      zero_blk   = (ZERO_REG_RO != 0) && (wa == '0);
      rf_we      = wr_act && !kill && !zero_blk;
      rf_waddr   = rf_we ? wa : '0;
      rf_wdata   = rf_we ? wd : '0;
      ex_ready   = ready_int || kill;
      pend_valid = pv_int && !kill;
      pend_addr  = pend_valid ? rd2_q : '0;
      // Non-writing transfers are simply consumed, so only writing ones matter.
      take       = ex_valid && ready_int && ex_reg_write;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= S_EMPTY;
         res_q  <= '0;
         rd1_q  <= '0;
         rd2_q  <= '0;
         swap_q <= 1'b0;
      end else if (flush) begin
         state <= S_EMPTY;
      end else begin
         case (state)
            S_EMPTY: begin
               if (take) state <= S_WR1;
            end
            S_WR1: begin
               if (swap_q)    state <= S_WR2;
               else if (take) state <= S_WR1;
               else           state <= S_EMPTY;
            end
            S_WR2: begin
               if (take) state <= S_WR1;
               else      state <= S_EMPTY;
            end
            default: state <= S_EMPTY;
         endcase
         if (take) begin
            res_q  <= ex_result;
            rd1_q  <= ex_rd1;
            rd2_q  <= ex_rd2;
            swap_q <= is_swap(ex_alu_ctrl);
         end
      end
   end

   wb_swap_sequencer_sat_counter #(
      .W(CNT_W)
   ) u_wr_count (
      .clk  (clk),
      .clr_n(rst_n),
      .inc  (rf_we),
      .count(wr_count)
   );

endmodule

// File: tb/tb_wb_swap_sequencer.sv
// tb/tb_wb_swap_sequencer.sv - self-checking bench for wb_swap_sequencer
module tb_wb_swap_sequencer;

   typedef struct {
      logic [3:0]  a;
      logic [15:0] d;
   } wr_t;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n = 1'b0;
   logic        rst_next = 1'b0;
   logic        flush = 1'b0;
   logic        ex_valid = 1'b0;
   logic        ex_reg_write = 1'b0;
   logic [2:0]  ex_alu_ctrl = 3'b000;
   logic [31:0] ex_result = 32'h0;
   logic [3:0]  ex_rd1 = 4'h0;
   logic [3:0]  ex_rd2 = 4'h0;

   logic        ex_ready, rf_we, pend_valid;
   logic [3:0]  rf_waddr, pend_addr;
   logic [15:0] rf_wdata, wr_count;

   logic        s_ex_ready, s_rf_we, s_pend_valid;
   logic [3:0]  s_rf_waddr, s_pend_addr, wr_count4;
   logic [15:0] s_rf_wdata;

   wb_swap_sequencer #(.DATA_W(16), .ADDR_W(4), .ZERO_REG_RO(1), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .ex_valid(ex_valid), .ex_ready(ex_ready),
      .ex_reg_write(ex_reg_write), .ex_alu_ctrl(ex_alu_ctrl), .ex_result(ex_result),
      .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .pend_valid(pend_valid), .pend_addr(pend_addr), .wr_count(wr_count)
   );

   wb_swap_sequencer #(.DATA_W(16), .ADDR_W(4), .ZERO_REG_RO(1), .CNT_W(4)) dut_sat (
      .clk(clk), .rst_n(rst_n), .flush(flush), .ex_valid(ex_valid), .ex_ready(s_ex_ready),
      .ex_reg_write(ex_reg_write), .ex_alu_ctrl(ex_alu_ctrl), .ex_result(ex_result),
      .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .rf_we(s_rf_we), .rf_waddr(s_rf_waddr), .rf_wdata(s_rf_wdata),
      .pend_valid(s_pend_valid), .pend_addr(s_pend_addr), .wr_count(wr_count4)
   );

   int total = 0;
   int bad = 0;

   // Reference model: a queue of writes still owed to the register file, one
   // retired per cycle; a SWAP enqueues two.
   wr_t q[$];
   int  cnt16 = 0;
   int  cnt4 = 0;
   logic        e_we, e_ready, e_pv;
   logic [3:0]  e_waddr, e_pa;
   logic [15:0] e_wdata;

   function automatic void model_outputs();
      e_we = 1'b0; e_ready = 1'b1; e_pv = 1'b0; e_waddr = 4'h0; e_pa = 4'h0; e_wdata = 16'h0;
      if (rst_n && !flush) begin
         if (q.size() > 0 && q[0].a != 4'h0) begin
            e_we = 1'b1; e_waddr = q[0].a; e_wdata = q[0].d;
         end
         e_ready = (q.size() <= 1);
         if (q.size() == 2) begin
            e_pv = 1'b1; e_pa = q[1].a;
         end
      end
   endfunction

   task automatic set_in(input logic v, input logic rw, input logic [2:0] c, input logic [31:0] r,
                         input logic [3:0] a1, input logic [3:0] a2, input logic fl);
      @(negedge clk);
      rst_n = rst_next; ex_valid = v; ex_reg_write = rw; ex_alu_ctrl = c; ex_result = r;
      ex_rd1 = a1; ex_rd2 = a2; flush = fl;
      #1;
      model_outputs();
   endtask

   task automatic tick();
      @(posedge clk);
      if (!rst_n) begin
         q.delete(); cnt16 = 0; cnt4 = 0;
      end else if (flush) begin
         q.delete();
      end else begin
         if (e_we) begin
            if (cnt16 < 65535) cnt16++;
            if (cnt4 < 15) cnt4++;
         end
         if (q.size() > 0) void'(q.pop_front());
         if (ex_valid && e_ready && ex_reg_write) begin
            q.push_back('{a: ex_rd1, d: ex_result[15:0]});
            if (ex_alu_ctrl == 3'b011) q.push_back('{a: ex_rd2, d: ex_result[31:16]});
         end
      end
   endtask

   task automatic test_reset();
      rst_next = 1'b0;
      for (int i = 0; i < 2; i++) begin
         set_in(1'b1, 1'b1, 3'b011, $urandom, 4'h5, 4'h6, 1'b0);
         total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b want=0", rf_we); end
         total++; if (ex_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", ex_ready); end
         total++; if (pend_valid !== 1'b0 || pend_addr !== 4'h0) begin bad++; $display("FAIL reset_pend got=%b/%h want=0/0", pend_valid, pend_addr); end
         total++; if (rf_waddr !== 4'h0 || rf_wdata !== 16'h0) begin bad++; $display("FAIL reset_wport got=%h/%h want=0/0", rf_waddr, rf_wdata); end
         if (i > 0) begin
            total++; if (wr_count !== 16'h0) begin bad++; $display("FAIL reset_cnt got=%h want=0", wr_count); end
         end
         tick();
      end
      rst_next = 1'b1;
   endtask

   task automatic test_add_stream();
      set_in(1'b1, 1'b1, 3'b000, 32'h0000_1234, 4'h3, 4'h0, 1'b0);
      total++; if (ex_ready !== 1'b1 || rf_we !== 1'b0) begin bad++; $display("FAIL add_c1 got ready=%b we=%b want 1/0", ex_ready, rf_we); end
      tick();
      set_in(1'b1, 1'b1, 3'b000, 32'h0000_00FF, 4'h4, 4'h0, 1'b0);
      total++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 4'h3, 16'h1234}) begin bad++; $display("FAIL add_w1 got %b,%h,%h want 1,3,1234", rf_we, rf_waddr, rf_wdata); end
      total++; if (ex_ready !== 1'b1) begin bad++; $display("FAIL add_ready got=%b want=1", ex_ready); end
      tick();
      set_in(1'b0, 1'b0, 3'b000, 32'h0, 4'h0, 4'h0, 1'b0);
      total++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 4'h4, 16'h00FF}) begin bad++; $display("FAIL add_w2 got %b,%h,%h want 1,4,00ff", rf_we, rf_waddr, rf_wdata); end
      tick();
      set_in(1'b0, 1'b0, 3'b000, 32'h0, 4'h0, 4'h0, 1'b0);
      total++; if (rf_we !== 1'b0 || wr_count !== 16'd2) begin bad++; $display("FAIL add_end got we=%b cnt=%0d want 0/2", rf_we, wr_count); end
      tick();
   endtask

   task automatic test_swap();
      set_in(1'b1, 1'b1, 3'b011, 32'hAAAA_5555, 4'h5, 4'h6, 1'b0);
      total++; if (ex_ready !== 1'b1) begin bad++; $display("FAIL swap_acc got=%b want=1", ex_ready); end
      tick();
      set_in(1'b1, 1'b1, 3'b000, 32'h0000_0777, 4'h7, 4'h0, 1'b0);
      total++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 4'h5, 16'h5555}) begin bad++; $display("FAIL swap_w1 got %b,%h,%h want 1,5,5555", rf_we, rf_waddr, rf_wdata); end
      total++; if ({ex_ready, pend_valid, pend_addr} !== {1'b0, 1'b1, 4'h6}) begin bad++; $display("FAIL swap_stall got ready=%b pv=%b pa=%h want 0,1,6", ex_ready, pend_valid, pend_addr); end
      tick();
      set_in(1'b1, 1'b1, 3'b000, 32'h0000_0777, 4'h7, 4'h0, 1'b0);
      total++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 4'h6, 16'hAAAA}) begin bad++; $display("FAIL swap_w2 got %b,%h,%h want 1,6,aaaa", rf_we, rf_waddr, rf_wdata); end
      total++; if ({ex_ready, pend_valid} !== 2'b10) begin bad++; $display("FAIL swap_wr2_hs got ready=%b pv=%b want 1,0", ex_ready, pend_valid); end
      tick();
      set_in(1'b0, 1'b0, 3'b000, 32'h0, 4'h0, 4'h0, 1'b0);
      total++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 4'h7, 16'h0777}) begin bad++; $display("FAIL swap_add got %b,%h,%h want 1,7,0777", rf_we, rf_waddr, rf_wdata); end
      tick();
      set_in(1'b0, 1'b0, 3'b000, 32'h0, 4'h0, 4'h0, 1'b0);
      total++; if (rf_we !== 1'b0 || wr_count !== 16'd5) begin bad++; $display("FAIL swap_end got we=%b cnt=%0d want 0/5", rf_we, wr_count); end
      tick();
   endtask

   task automatic test_zero_reg();
      set_in(1'b1, 1'b1, 3'b000, 32'h0000_0042, 4'h0, 4'h0, 1'b0);
      tick();
      set_in(1'b1, 1'b1, 3'b001, 32'h0000_0099, 4'h9, 4'h0, 1'b0);
      total++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b0, 4'h0, 16'h0}) begin bad++; $display("FAIL zero_sup got %b,%h,%h want 0,0,0", rf_we, rf_waddr, rf_wdata); end
      total++; if (ex_ready !== 1'b1) begin bad++; $display("FAIL zero_ready got=%b want=1", ex_ready); end
      tick();
      set_in(1'b0, 1'b0, 3'b000, 32'h0, 4'h0, 4'h0, 1'b0);
      total++; if (wr_count !== 16'd5) begin bad++; $display("FAIL zero_cnt got=%0d want=5", wr_count); end
      total++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 4'h9, 16'h0099}) begin bad++; $display("FAIL zero_next got %b,%h,%h want 1,9,0099", rf_we, rf_waddr, rf_wdata); end
      tick();
   endtask

   task automatic test_flush();
      set_in(1'b1, 1'b1, 3'b011, 32'hBEEF_CAFE, 4'h1, 4'h2, 1'b0);
      tick();
      set_in(1'b0, 1'b0, 3'b000, 32'h0, 4'h0, 4'h0, 1'b0);
      total++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 4'h1, 16'hCAFE}) begin bad++; $display("FAIL flush_w1 got %b,%h,%h want 1,1,cafe", rf_we, rf_waddr, rf_wdata); end
      tick();
      set_in(1'b1, 1'b1, 3'b000, 32'h0000_0808, 4'h8, 4'h0, 1'b1);
      total++; if ({rf_we, pend_valid, ex_ready} !== 3'b001) begin bad++; $display("FAIL flush_cyc got we=%b pv=%b ready=%b want 0,0,1", rf_we, pend_valid, ex_ready); end
      total++; if (rf_waddr !== 4'h0 || rf_wdata !== 16'h0) begin bad++; $display("FAIL flush_wport got %h/%h want 0/0", rf_waddr, rf_wdata); end
      tick();
      set_in(1'b0, 1'b0, 3'b000, 32'h0, 4'h0, 4'h0, 1'b0);
      total++; if ({rf_we, pend_valid, ex_ready} !== 3'b001) begin bad++; $display("FAIL flush_after got we=%b pv=%b ready=%b want 0,0,1", rf_we, pend_valid, ex_ready); end
      total++; if (wr_count !== 16'd7) begin bad++; $display("FAIL flush_cnt got=%0d want=7", wr_count); end
      tick();
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         rst_next = ($urandom_range(0, 99) != 0);
         set_in($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), $urandom,
                4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom_range(0, 19) == 0);
         total++; if (rf_we !== e_we) begin bad++; $display("FAIL rnd_we cyc=%0d got=%b want=%b", i, rf_we, e_we); end
         total++; if (rf_waddr !== e_waddr) begin bad++; $display("FAIL rnd_waddr cyc=%0d got=%h want=%h", i, rf_waddr, e_waddr); end
         total++; if (rf_wdata !== e_wdata) begin bad++; $display("FAIL rnd_wdata cyc=%0d got=%h want=%h", i, rf_wdata, e_wdata); end
         total++; if (ex_ready !== e_ready) begin bad++; $display("FAIL rnd_ready cyc=%0d got=%b want=%b", i, ex_ready, e_ready); end
         total++; if (pend_valid !== e_pv || pend_addr !== e_pa) begin bad++; $display("FAIL rnd_pend cyc=%0d got=%b/%h want=%b/%h", i, pend_valid, pend_addr, e_pv, e_pa); end
         if (i > 0) begin
            total++; if (wr_count !== 16'(cnt16)) begin bad++; $display("FAIL rnd_cnt cyc=%0d got=%0d want=%0d", i, wr_count, cnt16); end
            total++; if (wr_count4 !== 4'(cnt4)) begin bad++; $display("FAIL rnd_cnt4 cyc=%0d got=%0d want=%0d", i, wr_count4, cnt4); end
         end
         tick();
      end
      rst_next = 1'b1;
   endtask

   task automatic test_saturation();
      int want;
      rst_next = 1'b0;
      set_in(1'b0, 1'b0, 3'b000, 32'h0, 4'h0, 4'h0, 1'b0);
      tick();
      rst_next = 1'b1;
      for (int i = 0; i < 22; i++) begin
         set_in(1'b1, 1'b1, 3'b000, $urandom, 4'(1 + (i % 15)), 4'h0, 1'b0);
         want = (i > 0) ? i - 1 : 0;
         total++; if (wr_count !== 16'(want)) begin bad++; $display("FAIL sat_cnt16 i=%0d got=%0d want=%0d", i, wr_count, want); end
         total++; if (wr_count4 !== 4'((want > 15) ? 15 : want)) begin bad++; $display("FAIL sat_cnt4 i=%0d got=%0d want=%0d", i, wr_count4, (want > 15) ? 15 : want); end
         tick();
      end
      set_in(1'b0, 1'b0, 3'b000, 32'h0, 4'h0, 4'h0, 1'b0);
      total++; if (wr_count4 !== 4'hF) begin bad++; $display("FAIL sat_hold got=%h want=f", wr_count4); end
      tick();
   endtask

   initial begin
      test_reset();
      test_add_stream();
      test_swap();
      test_zero_reg();
      test_flush();
      test_random();
      test_saturation();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
